// File: rtl/control_sequencer.sv
// Instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC (EXEC_CYCLES) -> WB, plus a sticky HALT.
// Optional build macro CTRL_SEQ_WAIT_EN makes FETCH wait for fetch_ack.
module control_sequencer #(
   parameter int RD_W        = 2,
   parameter int EXEC_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en_in,
   input  logic                   fetch_ack,
   input  logic                   zero,
   input  logic [3:0]             opcode,
   input  logic [RD_W-1:0]        rd,
   output logic                   en_fetch_pulse,
   output logic                   en_group_pulse,
   output logic                   en_pc_pulse,
   output logic [1:0]             pc_ctrl,
   output logic [(2**RD_W)-1:0]   reg_en,
   output logic                   alu_in_sel,
   output logic [2:0]             alu_func,
   output logic                   halted
);

   localparam int         NREG      = 2**RD_W;
   localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);
   localparam logic [3:0] OP_JMP    = 4'b1000;
   localparam logic [3:0] OP_JZ     = 4'b1001;
   localparam logic [3:0] OP_HALT   = 4'b1010;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [3:0]        opcode_q, opcode_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic              fetch_held_q, fetch_held_d;
   logic              fetch_done;

`ifdef CTRL_SEQ_WAIT_EN
   assign fetch_done = fetch_ack;
`else
   logic unused_fetch_ack;
   assign unused_fetch_ack = fetch_ack;
   assign fetch_done       = 1'b1;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         opcode_q     <= '0;
         rd_q         <= '0;
         fetch_held_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         opcode_q     <= opcode_d;
         rd_q         <= rd_d;
         fetch_held_q <= fetch_held_d;
      end
   end

   // NOTE: every combinational output is given a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      opcode_d = opcode_q;
      rd_d     = rd_q;
      unique case (state_q)
         S_IDLE:   if (en_in) state_d = S_FETCH;
         S_FETCH:  if (fetch_done) state_d = S_DECODE;
         S_DECODE: begin
            opcode_d = opcode;
            rd_d     = rd;
            cnt_d    = EXEC_LOAD;
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            if (cnt_q == '0) state_d = S_WB;
            else             cnt_d   = cnt_q - 4'd1;
         end
         S_WB: begin
            if (opcode_q == OP_HALT) state_d = S_HALT;
            else if (en_in)          state_d = S_FETCH;
            else                     state_d = S_IDLE;
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
      // Remembers that the fetch strobe has already fired while FETCH is held.
      fetch_held_d = (state_q == S_FETCH) && (state_d == S_FETCH);
   end

   function automatic logic [3:0] alu_decode(input logic [3:0] op);
      logic [3:0] r;
      r = 4'b0000;
      if (op >= 4'd1 && op <= 4'd6) r = {1'b0, op[2:0]};
      else if (op == 4'd7)          r = 4'b1000;
      return r;
   endfunction

   always_comb begin
      en_fetch_pulse = 1'b0;
      en_group_pulse = 1'b0;
      en_pc_pulse    = 1'b0;
      pc_ctrl        = 2'b00;
      reg_en         = '0;
      alu_in_sel     = 1'b0;
      alu_func       = 3'b000;
      halted         = 1'b0;
      unique case (state_q)
         S_FETCH:  en_fetch_pulse = !fetch_held_q;
         S_DECODE: en_group_pulse = 1'b1;
         S_EXEC:   {alu_in_sel, alu_func} = alu_decode(opcode_q);
         S_WB: begin
            if (opcode_q >= 4'd1 && opcode_q <= 4'd7)
               reg_en = NREG'(1) << rd_q;
            if (opcode_q != OP_HALT) begin
               en_pc_pulse = 1'b1;
               if (opcode_q == OP_JMP || (opcode_q == OP_JZ && zero)) pc_ctrl = 2'b10;
               else                                                   pc_ctrl = 2'b01;
            end
         end
         S_HALT:   halted = 1'b1;
         default:  ;
      endcase
   end

endmodule
